// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR / interrupt unit.
// Contents: CSR addresses, mstatus bit positions, the bit offset of the
// interrupt lines inside mie/mip/mcause, and the redirect FSM state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // irq[i] lives at bit IRQ_OFFSET+i of mie/mip and gives cause code IRQ_OFFSET+i
  localparam int IRQ_OFFSET = 16;

  // Wide enough for up to 16 interrupt lines
  localparam int IRQ_IDX_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/irq_prio.sv
// Fixed-priority encoder: the lowest-numbered asserted request wins.
// Ports:
//   req   - request vector (NUM_IRQ bits)
//   valid - at least one request is asserted
//   idx   - index of the winning request (0 when none)
module irq_prio
  import csr_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   req,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan from the top down so the lowest set index is the last one written
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with level-sensitive interrupt take and mret handling.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   csr_addr/wdata/wr/rd - csrrw access from the memory/writeback stage
//   is_mret, pc_wb       - mret flag and PC of the memory/writeback instruction
//   irq                  - level-sensitive interrupt requests
//   csr_rdata            - combinational read data (pre-write value)
//   epc, epc_taken       - fetch redirect target and one-cycle strobe
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int               NUM_IRQ   = 4,
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_0040
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  input  logic               csr_wr,
  input  logic               csr_rd,
  input  logic               is_mret,
  input  logic [XLEN-1:0]    pc_wb,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [XLEN-1:0]    csr_rdata,
  output logic [XLEN-1:0]    epc,
  output logic               epc_taken
);

  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e               state_q, state_d;
  logic                 redir_mret_q, redir_mret_d;   // redirect was caused by mret
  logic                 mstatus_mie_q, mstatus_mie_d;
  logic                 mstatus_mpie_q, mstatus_mpie_d;
  logic [NUM_IRQ-1:0]   mie_q, mie_d;
  logic [NUM_IRQ-1:0]   pend_q, pend_d;
  logic [XLEN-1:0]      mtvec_q, mtvec_d;
  logic [XLEN-1:0]      mepc_q, mepc_d;
  logic [XLEN-1:0]      mcause_q, mcause_d;

  logic                 prio_valid;
  logic [IRQ_IDX_W-1:0] prio_idx;
  logic                 take;
  logic [XLEN-1:0]      cause_val;
  logic [XLEN-1:0]      trap_base;

  irq_prio #(.NUM_IRQ(NUM_IRQ)) u_irq_prio (
    .req   (pend_q & mie_q),
    .valid (prio_valid),
    .idx   (prio_idx)
  );

  assign take = (state_q == RUN) & mstatus_mie_q & prio_valid & ~csr_wr & ~is_mret;

  always_comb begin
    cause_val            = '0;
    cause_val[XLEN-1]    = 1'b1;
    cause_val[4:0]       = 5'(IRQ_OFFSET) + 5'(prio_idx);
  end

  // Read mux: returns the current (pre-write) register contents
  always_comb begin
    csr_rdata = '0;
    if (csr_rd) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
          csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        end
        CSR_MIE:    csr_rdata[IRQ_OFFSET +: NUM_IRQ] = mie_q;
        CSR_MTVEC:  csr_rdata = mtvec_q;
        CSR_MEPC:   csr_rdata = mepc_q;
        CSR_MCAUSE: csr_rdata = mcause_q;
        CSR_MIP:    csr_rdata[IRQ_OFFSET +: NUM_IRQ] = pend_q;
        default:    csr_rdata = '0;
      endcase
    end
  end

  // Next-state: software writes first, then trap/mret side effects override
  always_comb begin
    state_d        = state_q;
    redir_mret_d   = redir_mret_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    pend_d         = irq;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;

    if (csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
          mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mie_d    = csr_wdata[IRQ_OFFSET +: NUM_IRQ];
        CSR_MTVEC:  mtvec_d  = csr_wdata;
        CSR_MEPC:   mepc_d   = csr_wdata & WORD_MASK;
        CSR_MCAUSE: mcause_d = csr_wdata;
        default: ;
      endcase
    end

    if (state_q == RUN) begin
      if (is_mret) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
        redir_mret_d   = 1'b1;
        state_d        = REDIRECT;
      end else if (take) begin
        mepc_d         = pc_wb & WORD_MASK;
        mcause_d       = cause_val;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
        redir_mret_d   = 1'b0;
        state_d        = REDIRECT;
      end
    end else begin
      // Redirect is a single cycle; pending lines are looked at again in RUN
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      redir_mret_q   <= 1'b0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      pend_q         <= '0;
      mtvec_q        <= MTVEC_RST;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      state_q        <= state_d;
      redir_mret_q   <= redir_mret_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      pend_q         <= pend_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign epc_taken = (state_q == REDIRECT);

  // Vectored mode adds 4*cause code; the interrupt flag bit is not part of the offset
  always_comb begin
    epc = '0;
    if (state_q == REDIRECT) begin
      if (redir_mret_q)              epc = mepc_q;
      else if (mtvec_q[1:0] == 2'b01) epc = trap_base + {mcause_q[XLEN-3:0], 2'b00};
      else                            epc = trap_base;
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
module tb_csr_irq_unit;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr;
  logic        csr_rd;
  logic        is_mret;
  logic [31:0] pc_wb;
  logic [3:0]  irq;
  logic [31:0] csr_rdata;
  logic [31:0] epc;
  logic        epc_taken;

  int checks   = 0;
  int failures = 0;

  csr_irq_unit dut (
    .clk       (clk),
    .reset     (reset),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_wr    (csr_wr),
    .csr_rd    (csr_rd),
    .is_mret   (is_mret),
    .pc_wb     (pc_wb),
    .irq       (irq),
    .csr_rdata (csr_rdata),
    .epc       (epc),
    .epc_taken (epc_taken)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_addr = a;
    csr_rd   = 1'b1;
    #1;
    v        = csr_rdata;
    csr_rd   = 1'b0;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  // Called at a falling edge; the write lands on the next rising edge
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wr    = 1'b1;
    @(negedge clk);
    csr_wr    = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_taken"},   {31'd0, epc_taken}, 32'h0);
    check({pfx, "_epc"},     epc, 32'h0);
    check_csr({pfx, "_mstatus"}, A_MSTATUS, 32'h0);
    check_csr({pfx, "_mie"},     A_MIE,     32'h0);
    check_csr({pfx, "_mtvec"},   A_MTVEC,   32'h40);
    check_csr({pfx, "_mepc"},    A_MEPC,    32'h0);
    check_csr({pfx, "_mcause"},  A_MCAUSE,  32'h0);
    check_csr({pfx, "_mip"},     A_MIP,     32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; csr_addr = '0; csr_wdata = '0; csr_wr = 1'b0; csr_rd = 1'b0;
    is_mret = 1'b0; pc_wb = '0; irq = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    // Read strobe low and unknown addresses both read zero
    csr_addr = A_MTVEC; csr_rd = 1'b0; #1;
    check("rd_low", csr_rdata, 32'h0);
    check_csr("rd_unknown", 12'h7C0, 32'h0);

    // Basic trap on irq[0], direct mode
    wr(A_MIE, 32'h0001_0000);
    wr(A_MSTATUS, 32'h0000_0008);
    wr(A_MTVEC, 32'h0000_0040);
    check_csr("wr_mstatus", A_MSTATUS, 32'h8);
    check_csr("wr_mie", A_MIE, 32'h0001_0000);
    check_csr("wr_mtvec", A_MTVEC, 32'h40);
    wr(A_MIP, 32'hFFFF_FFFF);
    check_csr("mip_ro", A_MIP, 32'h0);

    irq = 4'b0001; pc_wb = 32'h1C;
    @(negedge clk);
    check("t1_latency", {31'd0, epc_taken}, 32'h0);
    @(negedge clk);
    check("t1_taken", {31'd0, epc_taken}, 32'h1);
    check("t1_epc", epc, 32'h40);
    check_csr("t1_mepc", A_MEPC, 32'h1C);
    check_csr("t1_mcause", A_MCAUSE, 32'h8000_0010);
    check_csr("t1_mstatus", A_MSTATUS, 32'h80);
    irq = 4'b0000;
    @(negedge clk);
    check("t1_one_cycle", {31'd0, epc_taken}, 32'h0);
    check("t1_epc_run", epc, 32'h0);

    // Pulse irq while MIE=0: visible in mip for one cycle, no redirect
    irq = 4'b0001;
    @(negedge clk);
    irq = 4'b0000;
    check_csr("pulse_mip_set", A_MIP, 32'h0001_0000);
    check("pulse_no_take0", {31'd0, epc_taken}, 32'h0);
    @(negedge clk);
    check_csr("pulse_mip_clr", A_MIP, 32'h0);
    check("pulse_no_take1", {31'd0, epc_taken}, 32'h0);
    @(negedge clk);
    check("pulse_no_take2", {31'd0, epc_taken}, 32'h0);

    // mret back to the trapped PC
    is_mret = 1'b1;
    @(negedge clk);
    is_mret = 1'b0;
    check("mret_taken", {31'd0, epc_taken}, 32'h1);
    check("mret_epc", epc, 32'h1C);
    check_csr("mret_mstatus", A_MSTATUS, 32'h88);
    @(negedge clk);
    check("mret_done", {31'd0, epc_taken}, 32'h0);

    // Two lines at once, vectored mode: lowest index (1) wins
    wr(A_MIE, 32'h000A_0000);
    wr(A_MTVEC, 32'h0000_0041);
    irq = 4'b1010; pc_wb = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("t2_taken", {31'd0, epc_taken}, 32'h1);
    check("t2_epc", epc, 32'h84);
    check_csr("t2_mcause", A_MCAUSE, 32'h8000_0011);
    check_csr("t2_mepc", A_MEPC, 32'h100);
    irq = 4'b0000;
    @(negedge clk);
    is_mret = 1'b1;
    @(negedge clk);
    is_mret = 1'b0;
    check("t2_mret_epc", epc, 32'h100);
    check_csr("t2_mret_mstatus", A_MSTATUS, 32'h88);
    @(negedge clk);

    // Take deferred by a coincident CSR write, then taken with the new mtvec
    wr(A_MIE, 32'h0001_0000);
    irq = 4'b0001;
    @(negedge clk);
    wr(A_MTVEC, 32'h0000_0080);
    check("t3_deferred", {31'd0, epc_taken}, 32'h0);
    @(negedge clk);
    check("t3_taken", {31'd0, epc_taken}, 32'h1);
    check("t3_epc", epc, 32'h80);
    check_csr("t3_mcause", A_MCAUSE, 32'h8000_0010);

    // Reset while redirecting aborts the redirect and restores reset values
    irq = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst_redir");

    // mepc write drops the low two bits
    wr(A_MEPC, 32'h0000_0123);
    check_csr("mepc_align", A_MEPC, 32'h120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
